// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter.
// Contents: the FSM state type, the default watchdog limit, the widest
// supported master count, and a helper that expands an index to a one-hot
// vector.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT = 1023;
    localparam int unsigned MAX_M       = 8;

    // One-hot expansion at the widest supported size; callers size-cast the
    // result down to their own master count.
    function automatic logic [MAX_M-1:0] onehot(input logic [2:0] idx);
        logic [MAX_M-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Handshake/grant bundle between the read arbiter and the interconnect.
//   req_i       per-master ARVALID
//   ar_ready_i  ARREADY of the decoded slave for the granted master
//   rvalid_i    RVALID returned to the granted master
//   rready_i    RREADY of the granted master
//   rlast_i     RLAST returned to the granted master
//   grant_o     one-hot grant (registered)
//   grant_idx_o binary grant index (registered)
//   busy_o      transaction in progress
//   timeout_o   watchdog release pulse
// modport slave  : arbiter view
// modport master : interconnect / requester view
interface axi_rd_arbiter_if #(
    parameter int unsigned NUM_M = 3
);
    logic [NUM_M-1:0]         req_i;
    logic                     ar_ready_i;
    logic                     rvalid_i;
    logic                     rready_i;
    logic                     rlast_i;
    logic [NUM_M-1:0]         grant_o;
    logic [$clog2(NUM_M)-1:0] grant_idx_o;
    logic                     busy_o;
    logic                     timeout_o;

    modport slave (
        input  req_i, ar_ready_i, rvalid_i, rready_i, rlast_i,
        output grant_o, grant_idx_o, busy_o, timeout_o
    );

    modport master (
        output req_i, ar_ready_i, rvalid_i, rready_i, rlast_i,
        input  grant_o, grant_idx_o, busy_o, timeout_o
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i      request vector
//   last_idx_i index granted most recently
//   valid_o    at least one request present
//   idx_o      first requester found scanning upward from last_idx_i+1,
//              wrapping at NUM_M
module rr_pick #(
    parameter int unsigned NUM_M = 3
) (
    input  logic [NUM_M-1:0]         req_i,
    input  logic [$clog2(NUM_M)-1:0] last_idx_i,
    output logic                     valid_o,
    output logic [$clog2(NUM_M)-1:0] idx_o
);
    localparam int unsigned IDX_W = $clog2(NUM_M);

    always_comb begin
        logic        found;
        int unsigned cand;
        valid_o = |req_i;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..NUM_M visit every master once, ending on last_idx_i
        // itself so a lone repeat requester can still win.
        for (int unsigned k = 1; k <= NUM_M; k++) begin
            cand = (32'(last_idx_i) + k) % NUM_M;
            if (!found && req_i[IDX_W'(cand)]) begin
                idx_o = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin read-transaction arbiter. Grants one master, holds the grant
// across the AR handshake and every R beat, releases after the RLAST
// handshake, and force-releases a stalled transaction via a watchdog.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  axi_rd_arbiter_if.slave (requests/handshakes in, grant/status out)
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_M   = 3,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = 10
) (
    input logic              clk,
    input logic              rst,
    axi_rd_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_M);

    arb_state_e       state_q;
    logic [NUM_M-1:0] grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [IDX_W-1:0] last_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             g_req;
    logic             ar_hs;
    logic             r_hs;
    logic             wd_hit;

    rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req_i      (bus.req_i),
        .last_idx_i (last_idx_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_comb begin
        g_req  = bus.req_i[grant_idx_q];
        ar_hs  = (state_q == ST_ADDR) && g_req && bus.ar_ready_i;
        r_hs   = (state_q == ST_DATA) && bus.rvalid_i && bus.rready_i;
        // A handshake in the limit cycle counts as progress and suppresses
        // the release.
        wd_hit = (TIMEOUT != 0) && (state_q != ST_IDLE)
                 && (cnt_q == CNT_W'(TIMEOUT)) && !ar_hs && !r_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(NUM_M - 1);
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q     <= ST_ADDR;
                        grant_q     <= NUM_M'(onehot(3'(pick_idx)));
                        grant_idx_q <= pick_idx;
                        last_idx_q  <= pick_idx;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (!g_req || wd_hit) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        if (ar_hs) begin
                            state_q <= ST_DATA;
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if ((r_hs && bus.rlast_i) || wd_hit) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (r_hs) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.grant_idx_o = grant_idx_q;
    assign bus.busy_o      = busy_q;
    assign bus.timeout_o   = wd_hit;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (NUM_M=3, TIMEOUT=8).
module tb_axi_rd_arbiter;
    localparam int NM = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.NUM_M(NM)) bus ();

    axi_rd_arbiter #(
        .NUM_M   (NM),
        .TIMEOUT (TO),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: transaction-level view of the arbiter.
    bit m_busy;      // a master holds the grant
    bit m_addr;      // address phase not yet accepted
    int m_g;         // granted master
    int m_last;      // most recent grant
    int m_stall;     // cycles since grant or last R beat

    function automatic int pick(input logic [NM-1:0] r, input int last);
        for (int i = last + 1; i < NM; i++) if (r[i]) return i;
        for (int i = 0; i < NM; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic bit progress();
        if (m_addr) return bus.req_i[m_g] && bus.ar_ready_i;
        return bus.rvalid_i && bus.rready_i;
    endfunction

    function automatic bit m_timeout();
        return m_busy && (m_stall == TO) && !progress();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mcheck();
        chk("m_grant", int'(bus.grant_o), m_busy ? (1 << m_g) : 0);
        chk("m_busy", int'(bus.busy_o), int'(m_busy));
        chk("m_timeout", int'(bus.timeout_o), int'(m_timeout()));
        if (m_busy) chk("m_idx", int'(bus.grant_idx_o), m_g);
    endtask

    task automatic drive(input logic [NM-1:0] rq, input logic ar, rv, rr, rl, rs);
        bus.req_i      = rq;
        bus.ar_ready_i = ar;
        bus.rvalid_i   = rv;
        bus.rready_i   = rr;
        bus.rlast_i    = rl;
        rst            = rs;
        #1;
        mcheck();
    endtask

    // Advance one clock and move the model by the same rules.
    task automatic tick();
        bit to;
        int p;
        to = m_timeout();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_addr = 0; m_g = 0; m_last = NM - 1; m_stall = 0;
        end else if (!m_busy) begin
            p = pick(bus.req_i, m_last);
            if (p >= 0) begin
                m_busy = 1; m_addr = 1; m_g = p; m_last = p; m_stall = 0;
            end
        end else if (m_addr) begin
            if (!bus.req_i[m_g] || to) m_busy = 0;
            else begin
                if (bus.ar_ready_i) m_addr = 0;
                m_stall++;
            end
        end else begin
            if (bus.rvalid_i && bus.rready_i) begin
                if (bus.rlast_i) m_busy = 0;
                else m_stall = 0;
            end else if (to) m_busy = 0;
            else m_stall++;
        end
        #1;
    endtask

    typedef struct {
        logic [NM-1:0] req;
        logic          arr, rv, rr, rl, rs;
        logic [NM-1:0] g;
        logic          b;
        int            idx;
    } vec_t;

    vec_t tbl[22];

    initial begin
        bus.req_i = '0; bus.ar_ready_i = 0; bus.rvalid_i = 0;
        bus.rready_i = 0; bus.rlast_i = 0;
        rst = 1'b1;
        tick();

        // Reset, first grant, and fairness under all-requesting traffic.
        tbl[0] = '{3'b010, 0, 0, 0, 0, 1, 3'b000, 0, 0};
        tbl[1] = '{3'b010, 0, 0, 0, 0, 0, 3'b000, 0, 0};
        tbl[2] = '{3'b010, 1, 0, 0, 0, 0, 3'b010, 1, 1};
        tbl[3] = '{3'b000, 0, 1, 1, 1, 0, 3'b010, 1, 1};
        tbl[4] = '{3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0};
        tbl[5] = '{3'b111, 1, 1, 1, 1, 1, 3'b000, 0, 0};
        tbl[6] = '{3'b111, 1, 1, 1, 1, 0, 3'b000, 0, 0};
        for (int i = 0; i < 5; i++) begin
            tbl[7 + 3*i]  = '{3'b111, 1, 1, 1, 1, 0, 3'((1 << (i % 3))), 1, i % 3};
            tbl[8 + 3*i]  = '{3'b111, 1, 1, 1, 1, 0, 3'((1 << (i % 3))), 1, i % 3};
            if (i < 4) tbl[9 + 3*i] = '{3'b111, 1, 1, 1, 1, 0, 3'b000, 0, 0};
        end
        tbl[21] = '{3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0};

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].req, tbl[i].arr, tbl[i].rv, tbl[i].rr, tbl[i].rl, tbl[i].rs);
            chk($sformatf("tbl%0d_grant", i), int'(bus.grant_o), int'(tbl[i].g));
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy_o), int'(tbl[i].b));
            chk($sformatf("tbl%0d_to", i), int'(bus.timeout_o), 0);
            if (tbl[i].b) chk($sformatf("tbl%0d_idx", i), int'(bus.grant_idx_o), tbl[i].idx);
            tick();
        end

        // Burst hold: 4 beats on M2 with rready toggling, others requesting.
        drive(3'b100, 0, 0, 0, 0, 0); tick();
        drive(3'b100, 1, 0, 0, 0, 0); chk("burst_addr", int'(bus.grant_o), 4); tick();
        for (int b = 0; b < 7; b++) begin
            drive(3'b011, 0, 1, (b % 2 == 0), (b == 6), 0);
            chk("burst_hold", int'(bus.grant_o), 4);
            tick();
        end
        drive(3'b011, 0, 0, 0, 0, 0); chk("burst_release", int'(bus.grant_o), 0); tick();
        drive(3'b011, 1, 0, 0, 0, 0); chk("burst_next_m0", int'(bus.grant_o), 1); tick();
        drive(3'b000, 0, 1, 1, 1, 0); tick();

        // Watchdog: M1 accepted, no read data.
        drive(3'b010, 0, 0, 0, 0, 0); tick();
        drive(3'b010, 1, 0, 0, 0, 0); tick();
        for (int d = 1; d <= 8; d++) begin
            drive(3'b010, 0, 0, 1, 0, 0);
            chk("wd_pulse", int'(bus.timeout_o), int'(d == 8));
            tick();
        end
        drive(3'b000, 0, 0, 0, 0, 0);
        chk("wd_release", int'(bus.grant_o), 0);
        chk("wd_idle_no_pulse", int'(bus.timeout_o), 0);
        tick();
        // Beat on the limit cycle counts as progress.
        drive(3'b010, 0, 0, 0, 0, 0); tick();
        drive(3'b010, 1, 0, 0, 0, 0); tick();
        for (int d = 1; d <= 8; d++) begin
            drive(3'b010, 0, (d == 8), 1, 0, 0);
            chk("wd_beat_saves", int'(bus.timeout_o), 0);
            tick();
        end
        drive(3'b010, 0, 1, 1, 1, 0); chk("wd_beat_hold", int'(bus.grant_o), 2); tick();
        drive(3'b000, 0, 0, 0, 0, 0); tick();

        // Abandoned request: M0 drops ARVALID before ARREADY.
        drive(3'b001, 0, 0, 0, 0, 0); tick();
        drive(3'b000, 0, 0, 0, 0, 0); chk("abandon_grant_m0", int'(bus.grant_o), 1); tick();
        drive(3'b011, 0, 0, 0, 0, 0); chk("abandon_idle", int'(bus.grant_o), 0); tick();
        drive(3'b011, 1, 0, 0, 0, 0); chk("abandon_next_m1", int'(bus.grant_o), 2); tick();
        drive(3'b000, 0, 1, 1, 1, 0); tick();
        drive(3'b001, 0, 0, 0, 0, 0); tick();
        drive(3'b000, 0, 0, 0, 0, 0); tick();
        drive(3'b001, 0, 0, 0, 0, 0); tick();
        drive(3'b001, 1, 0, 0, 0, 0); chk("abandon_next_m0", int'(bus.grant_o), 1); tick();
        drive(3'b000, 0, 1, 1, 1, 0); tick();

        // Reset during beat 2 of a burst.
        drive(3'b111, 0, 0, 0, 0, 0); tick();
        drive(3'b111, 1, 0, 0, 0, 0); tick();
        drive(3'b111, 0, 1, 1, 0, 0); tick();
        drive(3'b111, 0, 1, 1, 0, 1); tick();
        drive(3'b111, 0, 0, 0, 0, 0);
        chk("rst_grant", int'(bus.grant_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        tick();
        drive(3'b111, 1, 0, 0, 0, 0); chk("rst_first_m0", int'(bus.grant_o), 1); tick();
        drive(3'b000, 0, 1, 1, 1, 0); tick();

        // Randomized traffic against the model.
        for (int blk = 0; blk < 10; blk++) begin
            int p_rv = $urandom_range(10, 90);
            int p_ar = $urandom_range(20, 90);
            logic [NM-1:0] rq = NM'($urandom);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 99) < 15) rq = NM'($urandom);
                drive(rq,
                      $urandom_range(0, 99) < p_ar,
                      $urandom_range(0, 99) < p_rv,
                      $urandom_range(0, 99) < 70,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 199) == 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
